// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM (Moore style).
// Sequences the shared ALU, unified memory and the PC/IR/register-file write
// enables over 3-5 cycles per instruction. Memory accesses in FETCH, MEMRD and
// MEMWR wait on mem_ready. While rst_n is low every output is forced to 0.
//
// Handshake: the memory access request (MemRead/MemWrite plus IorD) is held
// steady from the first cycle of an access until the cycle where mem_ready=1.
// That cycle completes the transfer. Any write enable that depends on the
// transfer (IRWrite/PCWrite in FETCH, instr_done in MEMWR) asserts only then.
module multicycle_controller (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] op,
   input  logic       mem_ready,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       IorD,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       RegDst,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSource,
   output logic [3:0] state,
   output logic       instr_done,
   output logic       illegal_op
);

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC   = 4'd6,
      S_ALUWB  = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_ADDIEX = 4'd10,
      S_ADDIWB = 4'd11
   } state_t;

   state_t state_q, state_d;

   // State register; reset returns to FETCH immediately.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Next-state and control decode; reset overrides every output to 0.
   always_comb begin
      state_d     = S_FETCH;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      RegDst      = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
      instr_done  = 1'b0;
      illegal_op  = 1'b0;
      case (state_q)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            state_d = mem_ready ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            // Branch target is computed speculatively into ALUOut here.
            ALUSrcB = 2'b11;
            case (op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_EXEC;
               OP_BEQ:       state_d = S_BRANCH;
               OP_J:         state_d = S_JUMP;
               OP_ADDI:      state_d = S_ADDIEX;
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            if (op == OP_LW)      state_d = S_MEMRD;
            else if (op == OP_SW) state_d = S_MEMWR;
            else                  state_d = S_FETCH;
         end
         S_MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
            state_d = mem_ready ? S_MEMWB : S_MEMRD;
         end
         S_MEMWB: begin
            MemtoReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_MEMWR: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
            state_d    = mem_ready ? S_FETCH : S_MEMWR;
         end
         S_EXEC: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         S_BRANCH: begin
            ALUSrcA     = 1'b1;
            ALUOp       = 2'b01;
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
            instr_done  = 1'b1;
         end
         S_JUMP: begin
            PCWrite    = 1'b1;
            PCSource   = 2'b10;
            instr_done = 1'b1;
         end
         S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = S_ADDIWB;
         end
         S_ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         default: ; // codes 12-15: all outputs 0, back to FETCH
      endcase
      if (!rst_n) begin
         PCWrite     = 1'b0;
         PCWriteCond = 1'b0;
         IorD        = 1'b0;
         MemRead     = 1'b0;
         MemWrite    = 1'b0;
         IRWrite     = 1'b0;
         MemtoReg    = 1'b0;
         RegWrite    = 1'b0;
         RegDst      = 1'b0;
         ALUSrcA     = 1'b0;
         ALUSrcB     = 2'b00;
         ALUOp       = 2'b00;
         PCSource    = 2'b00;
         instr_done  = 1'b0;
         illegal_op  = 1'b0;
      end
   end

   assign state = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: a per-instruction expected trace of
// (state, mem_ready) is built from the instruction class and wait counts,
// and each cycle's outputs are compared against the per-state control table.
module tb_multicycle_controller;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [5:0] op;
   logic       mem_ready;
   logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
   logic       MemtoReg, RegWrite, RegDst, ALUSrcA;
   logic [1:0] ALUSrcB, ALUOp, PCSource;
   logic [3:0] state;
   logic       instr_done, illegal_op;
   logic [17:0] dut_ctrl;

   int checks = 0;
   int errors = 0;

   multicycle_controller dut (
      .clk(clk), .rst_n(rst_n), .op(op), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .MemtoReg(MemtoReg), .RegWrite(RegWrite), .RegDst(RegDst),
      .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
      .PCSource(PCSource), .state(state), .instr_done(instr_done),
      .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   assign dut_ctrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                      MemtoReg, RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp,
                      PCSource, instr_done, illegal_op};

   function automatic logic is_legal(logic [5:0] o);
      return (o == OP_RTYPE) || (o == OP_LW) || (o == OP_SW) ||
             (o == OP_BEQ) || (o == OP_J) || (o == OP_ADDI);
   endfunction

   // Control table: what each state must drive.
   function automatic logic [17:0] exp_ctrl(int st, logic rdy, logic [5:0] o);
      logic pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, sa, done, ill;
      logic [1:0] sb, aop, pcs;
      {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, sa, done, ill} = '0;
      sb = 2'b00; aop = 2'b00; pcs = 2'b00;
      case (st)
         0:  begin mr = 1; sb = 2'b01; irw = rdy; pcw = rdy; end
         1:  begin sb = 2'b11; ill = !is_legal(o); end
         2:  begin sa = 1; sb = 2'b10; end
         3:  begin mr = 1; iord = 1; end
         4:  begin m2r = 1; rw = 1; done = 1; end
         5:  begin mw = 1; iord = 1; done = rdy; end
         6:  begin sa = 1; aop = 2'b10; end
         7:  begin rd = 1; rw = 1; done = 1; end
         8:  begin sa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
         9:  begin pcw = 1; pcs = 2'b10; done = 1; end
         10: begin sa = 1; sb = 2'b10; end
         11: begin rw = 1; done = 1; end
         default: ;
      endcase
      return {pcw, pcwc, iord, mr, mw, irw, m2r, rw, rd, sa, sb, aop, pcs, done, ill};
   endfunction

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One cycle: drive mem_ready, compare, advance to the next falling edge.
   task automatic step(int st, logic rdy, output logic done_o);
      mem_ready = rdy;
      #1;
      check("state", 32'(state), 32'(st));
      check("ctrl", 32'(dut_ctrl), 32'(exp_ctrl(st, rdy, op)));
      done_o = instr_done;
      @(negedge clk);
   endtask

   // Builds the expected state trace of one instruction and walks it.
   task automatic run_instr(logic [5:0] o, int wf, int wm);
      int   sts[$];
      logic rs[$];
      logic d;
      int   done_cnt = 0;
      int   lat = 0;
      op = o;
      for (int i = 0; i < wf; i++) begin sts.push_back(0); rs.push_back(1'b0); end
      sts.push_back(0); rs.push_back(1'b1);
      sts.push_back(1); rs.push_back(1'($urandom_range(0, 1)));
      if (o == OP_LW || o == OP_SW) begin
         sts.push_back(2); rs.push_back(1'($urandom_range(0, 1)));
         for (int i = 0; i < wm; i++) begin
            sts.push_back(o == OP_LW ? 3 : 5); rs.push_back(1'b0);
         end
         sts.push_back(o == OP_LW ? 3 : 5); rs.push_back(1'b1);
         if (o == OP_LW) begin sts.push_back(4); rs.push_back(1'($urandom_range(0, 1))); end
      end else if (o == OP_RTYPE) begin
         sts.push_back(6); rs.push_back(1'($urandom_range(0, 1)));
         sts.push_back(7); rs.push_back(1'($urandom_range(0, 1)));
      end else if (o == OP_BEQ) begin
         sts.push_back(8); rs.push_back(1'($urandom_range(0, 1)));
      end else if (o == OP_J) begin
         sts.push_back(9); rs.push_back(1'($urandom_range(0, 1)));
      end else if (o == OP_ADDI) begin
         sts.push_back(10); rs.push_back(1'($urandom_range(0, 1)));
         sts.push_back(11); rs.push_back(1'($urandom_range(0, 1)));
      end
      for (int i = 0; i < sts.size(); i++) begin
         step(sts[i], rs[i], d);
         if (d === 1'b1) begin done_cnt++; lat = i + 1; end
      end
      check("done_count", 32'(done_cnt), is_legal(o) ? 32'd1 : 32'd0);
      if (is_legal(o)) begin
         int base;
         case (o)
            OP_BEQ, OP_J: base = 3;
            OP_LW:        base = 5;
            default:      base = 4;
         endcase
         if (o == OP_LW || o == OP_SW) base += wm;
         check("latency", 32'(lat), 32'(base + wf));
      end
   endtask

   logic [5:0] op_tab [8];
   logic       dd;

   initial begin
      op_tab = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, 6'b111111, 6'b001111};
      rst_n = 1'b0; mem_ready = 1'b1; op = OP_LW;
      repeat (3) @(negedge clk);
      #1;
      check("reset_ctrl", 32'(dut_ctrl), 32'd0);
      check("reset_state", 32'(state), 32'd0);
      rst_n = 1'b1;
      #1;
      check("release_fetch", 32'({MemRead, PCWrite, IRWrite}), 32'b111);

      // Directed sequence.
      run_instr(OP_LW, 0, 0);
      run_instr(OP_SW, 0, 2);
      run_instr(OP_BEQ, 0, 0);
      run_instr(OP_J, 0, 0);
      run_instr(OP_RTYPE, 0, 0);
      run_instr(OP_ADDI, 0, 0);
      run_instr(6'b111111, 0, 0);
      run_instr(OP_LW, 2, 1);

      // Randomized instruction stream with random wait states.
      for (int n = 0; n < 60; n++)
         run_instr(op_tab[$urandom_range(0, 7)], $urandom_range(0, 2), $urandom_range(0, 3));

      // Reset asserted while a store is waiting on memory.
      op = OP_SW;
      step(0, 1'b1, dd);
      step(1, 1'b1, dd);
      step(2, 1'b1, dd);
      mem_ready = 1'b0;
      #1;
      check("memwr_before_reset", 32'(MemWrite), 32'd1);
      rst_n = 1'b0;
      #1;
      check("memwr_drop", 32'(MemWrite), 32'd0);
      check("reset_mid_ctrl", 32'(dut_ctrl), 32'd0);
      check("reset_mid_state", 32'(state), 32'd0);
      mem_ready = 1'b1;
      @(negedge clk);
      #1;
      check("reset_hold_ctrl", 32'(dut_ctrl), 32'd0);
      rst_n = 1'b1;
      run_instr(OP_LW, 1, 1);
      run_instr(OP_SW, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Moore-style control FSM for the multi-cycle MIPS datapath: it sequences one shared ALU, one unified instruction/data memory and the PC/IR/register-file write enables across 3–5 cycles per instruction. It sits beside the datapath and takes the opcode from the instruction register. It takes a memory-ready handshake so fetch and data accesses can wait on slow memory. The opcode decode matches the single-cycle controller: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010. It adds addi 001000.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- op  in  6  opcode from the instruction register, IR[31:26]
- mem_ready  in  1  memory has completed the current read or write this cycle
- PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegWrite, RegDst, ALUSrcA  out  1 each  datapath controls
- ALUSrcB  out  2  00 = B register, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- ALUOp  out  2  00 = add, 01 = subtract, 10 = funct-decoded
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state, for debug and verification
- instr_done  out  1  one-cycle pulse on the final cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode

## Operation
- Registered 4-bit state register. All outputs are combinational decodes of the state, plus `mem_ready` and `op` where stated. Any output not listed for a state is 0.
- **FETCH (0):**
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=mem_ready, PCWrite=mem_ready.
  - Next state: DECODE if mem_ready, else FETCH.
- **DECODE (1):** ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by op:
  - lw or sw → MEMADR
  - R-type → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - any other op → FETCH, with illegal_op=1 this cycle
- **MEMADR (2):** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: MEMRD if op=lw, MEMWR if op=sw.
- **MEMRD (3):** MemRead=1, IorD=1. Next state: MEMWB if mem_ready, else MEMRD.
- **MEMWB (4):** RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next state: FETCH.
- **MEMWR (5):** MemWrite=1, IorD=1, instr_done=mem_ready. Next state: FETCH if mem_ready, else MEMWR.
- **EXEC (6):** ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next state: ALUWB.
- **ALUWB (7):** RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next state: FETCH.
- **BRANCH (8):** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next state: FETCH.
- **JUMP (9):** PCWrite=1, PCSource=10, instr_done=1. Next state: FETCH.
- **ADDIEX (10):** ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next state: ADDIWB.
- **ADDIWB (11):** RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next state: FETCH.
- **Codes 12–15:** unreachable. If entered, all outputs are 0 and the next state is FETCH.
- `op` is sampled only in DECODE and MEMADR. The IR is stable there because IRWrite is 0 outside FETCH.

## Timing
- **Reset:**
  - rst_n low forces state=FETCH asynchronously.
  - While rst_n=0, every output is forced to 0 combinationally, including PCWrite, IRWrite and MemRead, regardless of mem_ready. `state` reads 0.
  - First fetch cycle is the first rising edge after rst_n deasserts.
- **Reset mid-instruction:** the instruction is abandoned immediately and no write enable is asserted afterwards. A pending MemWrite drops in the same cycle rst_n falls.
- **Latency with zero wait states, counting from the first FETCH cycle through the instr_done cycle:**
  - 3 cycles: beq, j
  - 4 cycles: R-type, sw, addi
  - 5 cycles: lw
  - 2 cycles (no instr_done): illegal op
- **Memory wait states:** each cycle with mem_ready=0 in FETCH, MEMRD or MEMWR adds exactly one cycle.
  - MemRead or MemWrite and the address select are held steady throughout.
  - IRWrite and PCWrite stay 0 until the ready cycle.
- mem_ready is ignored in every other state.
- Back-to-back instructions: FETCH follows the instr_done cycle with no bubble.

## Test plan
- **Reset:** hold rst_n=0 with mem_ready=1 → all outputs 0 and state=0. Release rst_n → next cycle has MemRead=1, PCWrite=1, IRWrite=1.
- **lw, mem_ready always 1:** state sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4. instr_done pulses exactly once.
- **sw with two memory wait states:** state 5 is held for 3 cycles, MemWrite=1 and IorD=1 throughout. instr_done=1 only on the ready cycle, then FETCH.
- **beq:** state 8 has PCWriteCond=1, ALUOp=01, PCSource=01. **j:** state 9 has PCWrite=1, PCSource=10. Both return to 0.
- **R-type then addi back-to-back:**
  - States 0,1,6,7,0,1,10,11,0.
  - RegDst is 1 in state 7 and 0 in state 11.
  - ALUOp is 10 in state 6 and 00 in state 10.
- **Illegal op 111111:** illegal_op pulses in DECODE, no write enable asserts, return to FETCH. Separately, asserting reset during MEMWR drops MemWrite the same cycle.
